ds1620_responder: RTL and testbench
===================================

Name: ds1620_responder

Overview:
- Slave-side model of the DS1620 3-wire serial port (DS_CLK, DS_RST, DQ), clocked by the system clock and fed from the master's bus pins.
- Oversamples the bus, receives an 8-bit command LSB-first, then returns temperature or config data, accepts a config byte, or latches start/stop conversion.
- Acts as the synthesizable sensor stand-in for board bring-up and closed-loop simulation of the DS1620 master interface.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on DS_CLK, DS_RST and DQ_IN (minimum 2).
- TEMP_BITS, 9, width of the temperature word returned by READ_TEMP.
- CFG_RESET, 8'h02, reset value of the config register (CPU bit set).

Ports:
- CLK_IN  in  1  system clock; all logic on its rising edge.
- CLR  in  1  synchronous active-high reset.
- DS_CLK  in  1  serial clock from the master (asynchronous to CLK_IN).
- DS_RST  in  1  frame enable from the master; high = transfer active, low = interface reset.
- DQ_IN  in  1  serial data from the master.
- DQ_OUT  out  1  serial data to the master.
- DQ_OE  out  1  tristate enable for DQ_OUT; high while the responder drives the bus.
- TEMP_SRC  in  TEMP_BITS  temperature value to report; captured at the start of TX.
- CFG  out  8  config register.
- CONV_ACTIVE  out  1  set by START_CONVERT, cleared by STOP_CONVERT.
- CMD  out  8  last received command byte.
- CMD_VALID  out  1  one-cycle pulse when a command byte completes.
- PROTO_ERR  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (CLR=1, synchronous): DQ_OUT=0, DQ_OE=0, CFG=CFG_RESET, CONV_ACTIVE=0, CMD=0, CMD_VALID=0, PROTO_ERR=0, state=IDLE, synchronizers=0.
- Input path: each input passes through SYNC_STAGES flops, then a 1-cycle edge detector.
  - An event is acted on SYNC_STAGES+1 CLK_IN cycles after the pin changes.
  - Required DS_CLK high and low times: at least SYNC_STAGES+2 CLK_IN cycles each.
- Bus rules:
  - DQ is sampled on synchronized DS_CLK rising edges.
  - Responder output changes on synchronized DS_CLK falling edges.
  - All transfers are LSB-first.
- Commands (ds1620_pkg):
  - READ_TEMP 8'hAA: TX TEMP_BITS bits.
  - READ_CFG 8'hAC: TX 8 bits.
  - WRITE_CFG 8'h0C: RX 8 bits.
  - START_CONVERT 8'hEE.
  - STOP_CONVERT 8'h22.
- States:
  - IDLE: DS_RST rising edge -> CMD, bit count=0.
  - CMD: shift DQ on each rising edge. On the 8th bit:
    - Load CMD and pulse CMD_VALID.
    - AA/AC -> TX; capture TEMP_SRC or CFG into the shift register and set length.
    - 0C -> RXDATA.
    - EE/22 -> update CONV_ACTIVE, go to DONE.
    - Any other value -> DONE.
  - TX:
    - On the first falling edge: DQ_OE=1, DQ_OUT=bit0.
    - On each later falling edge: shift out the next bit.
    - On the rising edge that samples the last bit -> DONE.
    - DQ_OE stays 1 until the next falling edge or a DS_RST low.
  - RXDATA: shift 8 bits on rising edges; on the 8th bit write CFG[7:0] and go to DONE.
  - DONE: ignore DS_CLK and keep DQ_OE=0 until DS_RST goes low.
- DS_RST low (synchronized) in any state:
  - Next cycle: state=IDLE, DQ_OE=0, DQ_OUT=0.
  - A partial RXDATA leaves CFG unchanged.
  - A partial CMD does not pulse CMD_VALID.
- Edge ordering: a DS_RST falling edge in the same cycle as a DS_CLK edge takes priority; the clock edge is ignored.
- Extra DS_CLK edges in DONE have no effect. DS_RST held high never wraps into a new command.
- CLR overrides everything, including mid-frame.

Optional Feature:
- Macro: DS1620_PROTO_ERR_EN.
- Defined: PROTO_ERR sets, and stays set until CLR, on any of:
  - an unknown command byte;
  - DS_RST dropping in CMD/TX/RXDATA before the frame completes;
  - a DS_CLK rising edge while synchronized DS_RST is low.
- Undefined: PROTO_ERR is tied 0 and the detection logic is not compiled.

Decomposition:
- ds1620_pkg holds:
  - command constants (CMD_READ_TEMP, CMD_READ_CFG, CMD_WRITE_CFG, CMD_START_CONV, CMD_STOP_CONV);
  - the state enumeration (IDLE, CMD, TX, RXDATA, DONE);
  - the CFG_RESET default.
- Sub-module ds_sync_edge: a SYNC_STAGES-deep synchronizer plus rise/fall pulse outputs; instantiated three times.

Test Plan:
- CLR held 10 cycles -> all outputs at reset values, CFG=8'h02.
- READ_TEMP with TEMP_SRC=9'h032, DS_CLK half period 10 CLK_IN cycles:
  - CMD_VALID pulses once with CMD=8'hAA.
  - Master samples 0,1,0,0,1,1,0,0,0 on rising edges 9-17.
  - DQ_OE falls after DS_RST low.
- WRITE_CFG 8'h0C with data 8'hA5, then READ_CFG in a new frame -> CFG=8'hA5 and the returned bits are 1,0,1,0,0,1,0,1.
- START_CONVERT 8'hEE -> CONV_ACTIVE=1; then STOP_CONVERT 8'h22 -> CONV_ACTIVE=0.
- DS_RST dropped after 3 bits of WRITE_CFG data -> CFG unchanged, state IDLE, DQ_OE=0; PROTO_ERR=1 with DS1620_PROTO_ERR_EN, 0 without.
- Unknown command 8'h55, then 4 extra DS_CLK pulses -> DQ_OE stays 0, CMD=8'h55; PROTO_ERR=1 only when the macro is defined.

Source files
------------

// File: rtl/ds1620_pkg.sv
// Shared constants for the DS1620 slave-side responder: command bytes,
// FSM state encodings and the default config register value.
package ds1620_pkg;

  localparam logic [7:0] CMD_READ_TEMP  = 8'hAA;
  localparam logic [7:0] CMD_READ_CFG   = 8'hAC;
  localparam logic [7:0] CMD_WRITE_CFG  = 8'h0C;
  localparam logic [7:0] CMD_START_CONV = 8'hEE;
  localparam logic [7:0] CMD_STOP_CONV  = 8'h22;

  localparam logic [7:0] CFG_RESET_VAL  = 8'h02;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_TX     = 3'd2;
  localparam logic [2:0] ST_RXDATA = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/ds_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by a one-cycle
// rise/fall detector on the synchronized level.
module ds_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;
  logic              prev_reg;

  assign sync_next[0] = d;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/ds1620_responder.sv
// DS1620 3-wire slave responder: LSB-first command receive, temperature/config
// readback, config write and conversion start/stop. Optional DS1620_PROTO_ERR_EN.
module ds1620_responder
  import ds1620_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         TEMP_BITS   = 9,
  parameter logic [7:0] CFG_RESET   = CFG_RESET_VAL
) (
  input  logic                 CLK_IN,
  input  logic                 CLR,
  input  logic                 DS_CLK,
  input  logic                 DS_RST,
  input  logic                 DQ_IN,
  output logic                 DQ_OUT,
  output logic                 DQ_OE,
  input  logic [TEMP_BITS-1:0] TEMP_SRC,
  output logic [7:0]           CFG,
  output logic                 CONV_ACTIVE,
  output logic [7:0]           CMD,
  output logic                 CMD_VALID,
  output logic                 PROTO_ERR
);

  localparam int SH_W  = (TEMP_BITS > 8) ? TEMP_BITS : 8;
  localparam int CNT_W = $clog2(SH_W + 1);

  // Pin index: 0 = DS_CLK, 1 = DS_RST, 2 = DQ_IN
  logic [2:0] pin_vec;
  logic [2:0] level_vec;
  logic [2:0] rise_vec;
  logic [2:0] fall_vec;

  assign pin_vec = {DQ_IN, DS_RST, DS_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      ds_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (CLK_IN),
        .srst  (CLR),
        .d     (pin_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi]),
        .fall  (fall_vec[gi])
      );
    end
  endgenerate

  logic clk_rise, clk_fall, rst_lvl, rst_rise, dq_lvl;
  assign clk_rise = rise_vec[0];
  assign clk_fall = fall_vec[0];
  assign rst_lvl  = level_vec[1];
  assign rst_rise = rise_vec[1];
  assign dq_lvl   = level_vec[2];

  logic unused_edges;
  assign unused_edges = ^{fall_vec[1], rise_vec[2], fall_vec[2]};

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [SH_W-1:0]  tx_sh_reg, tx_sh_next;
  logic [7:0]       rx_sh_reg, rx_sh_next;
  logic             dq_out_reg, dq_out_next;
  logic             dq_oe_reg, dq_oe_next;
  logic [7:0]       cfg_reg, cfg_next;
  logic             conv_reg, conv_next;
  logic [7:0]       cmd_reg, cmd_next;
  logic             cmd_valid_reg, cmd_valid_next;
  logic [7:0]       rx_byte;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign rx_byte = {dq_lvl, rx_sh_reg[7:1]};

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    len_next       = len_reg;
    tx_sh_next     = tx_sh_reg;
    rx_sh_next     = rx_sh_reg;
    dq_out_next    = dq_out_reg;
    dq_oe_next     = dq_oe_reg;
    cfg_next       = cfg_reg;
    conv_next      = conv_reg;
    cmd_next       = cmd_reg;
    cmd_valid_next = 1'b0;

    // A low frame enable wins over any clock edge seen in the same cycle.
    if (!rst_lvl) begin
      state_next  = ST_IDLE;
      dq_oe_next  = 1'b0;
      dq_out_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rst_rise) begin
            state_next   = ST_CMD;
            bit_cnt_next = '0;
          end
        end
        ST_CMD: begin
          if (clk_rise) begin
            rx_sh_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == CNT_W'(7)) begin
              cmd_next       = rx_byte;
              cmd_valid_next = 1'b1;
              bit_cnt_next   = '0;
              case (rx_byte)
                CMD_READ_TEMP: begin
                  state_next = ST_TX;
                  tx_sh_next = SH_W'(TEMP_SRC);
                  len_next   = CNT_W'(TEMP_BITS);
                end
                CMD_READ_CFG: begin
                  state_next = ST_TX;
                  tx_sh_next = SH_W'(cfg_reg);
                  len_next   = CNT_W'(8);
                end
                CMD_WRITE_CFG:  state_next = ST_RXDATA;
                CMD_START_CONV: begin
                  conv_next  = 1'b1;
                  state_next = ST_DONE;
                end
                CMD_STOP_CONV: begin
                  conv_next  = 1'b0;
                  state_next = ST_DONE;
                end
                default:        state_next = ST_DONE;
              endcase
            end
          end
        end
        ST_TX: begin
          if (clk_fall) begin
            dq_oe_next  = 1'b1;
            dq_out_next = tx_sh_reg[0];
            tx_sh_next  = tx_sh_reg >> 1;
          end else if (clk_rise) begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == len_reg - CNT_W'(1)) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_RXDATA: begin
          if (clk_rise) begin
            rx_sh_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == CNT_W'(7)) begin
              cfg_next   = rx_byte;
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // The last TX bit stays on the bus until the master's next falling edge.
          if (clk_fall) begin
            dq_oe_next  = 1'b0;
            dq_out_next = 1'b0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (CLR) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      len_reg       <= '0;
      tx_sh_reg     <= '0;
      rx_sh_reg     <= '0;
      dq_out_reg    <= 1'b0;
      dq_oe_reg     <= 1'b0;
      cfg_reg       <= CFG_RESET;
      conv_reg      <= 1'b0;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      len_reg       <= len_next;
      tx_sh_reg     <= tx_sh_next;
      rx_sh_reg     <= rx_sh_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
      cfg_reg       <= cfg_next;
      conv_reg      <= conv_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
    end
  end

`ifdef DS1620_PROTO_ERR_EN
  logic proto_err_reg;
  logic bad_cmd, frame_abort, stray_clk;

  assign bad_cmd     = cmd_valid_reg &&
                       (cmd_reg != CMD_READ_TEMP) && (cmd_reg != CMD_READ_CFG) &&
                       (cmd_reg != CMD_WRITE_CFG) && (cmd_reg != CMD_START_CONV) &&
                       (cmd_reg != CMD_STOP_CONV);
  assign frame_abort = !rst_lvl &&
                       ((state_reg == ST_CMD) || (state_reg == ST_TX) ||
                        (state_reg == ST_RXDATA));
  assign stray_clk   = clk_rise && !rst_lvl;

  always_ff @(posedge CLK_IN) begin
    if (CLR) begin
      proto_err_reg <= 1'b0;
    end else if (bad_cmd || frame_abort || stray_clk) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign PROTO_ERR = proto_err_reg;
`else
  assign PROTO_ERR = 1'b0;
`endif

  assign DQ_OUT      = dq_out_reg;
  assign DQ_OE       = dq_oe_reg;
  assign CFG         = cfg_reg;
  assign CONV_ACTIVE = conv_reg;
  assign CMD         = cmd_reg;
  assign CMD_VALID   = cmd_valid_reg;

endmodule

// File: tb/tb_ds1620_responder.sv
// Directed bench for ds1620_responder acting as a DS1620 master on the 3-wire bus.
module tb_ds1620_responder;
  import ds1620_pkg::*;

  localparam int HALF = 10;

  logic       CLK_IN = 1'b0;
  logic       CLR = 1'b1;
  logic       DS_CLK = 1'b0;
  logic       DS_RST = 1'b0;
  logic       DQ_IN = 1'b0;
  logic [8:0] TEMP_SRC = 9'h032;
  logic       DQ_OUT, DQ_OE, CONV_ACTIVE, CMD_VALID, PROTO_ERR;
  logic [7:0] CFG, CMD;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cv_total = 0;
  int cv_mark;
  logic exp_perr;
  logic [31:0] rd_word;
  logic oe_seen;

  ds1620_responder dut (
    .CLK_IN      (CLK_IN),
    .CLR         (CLR),
    .DS_CLK      (DS_CLK),
    .DS_RST      (DS_RST),
    .DQ_IN       (DQ_IN),
    .DQ_OUT      (DQ_OUT),
    .DQ_OE       (DQ_OE),
    .TEMP_SRC    (TEMP_SRC),
    .CFG         (CFG),
    .CONV_ACTIVE (CONV_ACTIVE),
    .CMD         (CMD),
    .CMD_VALID   (CMD_VALID),
    .PROTO_ERR   (PROTO_ERR)
  );

  always #5 CLK_IN = ~CLK_IN;

  always @(posedge CLK_IN) begin
    if (CMD_VALID) cv_total <= cv_total + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_IN);
  endtask

  task automatic frame_begin();
    DS_RST = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic frame_end();
    DS_RST = 1'b0;
    wait_cyc(HALF);
    DS_CLK = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic send_bits(input logic [7:0] val, input int n);
    logic [7:0] v;
    v = val;
    for (int i = 0; i < n; i++) begin
      DQ_IN = v[i];
      wait_cyc(HALF);
      DS_CLK = 1'b1;
      wait_cyc(HALF);
      DS_CLK = 1'b0;
    end
  endtask

  // Leaves DS_CLK high after the last sampling edge.
  task automatic read_bits(input int n, output logic [31:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      wait_cyc(HALF);
      word[i] = DQ_OUT;
      DS_CLK = 1'b1;
      wait_cyc(HALF);
      if (i < n - 1) DS_CLK = 1'b0;
    end
  endtask

  initial begin
`ifdef DS1620_PROTO_ERR_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    wait_cyc(10);
    check_val("rst_dq_out", 32'(DQ_OUT), 32'd0);
    check_val("rst_dq_oe", 32'(DQ_OE), 32'd0);
    check_val("rst_cfg", 32'(CFG), 32'h02);
    check_val("rst_conv", 32'(CONV_ACTIVE), 32'd0);
    check_val("rst_cmd", 32'(CMD), 32'd0);
    check_val("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
    check_val("rst_proto_err", 32'(PROTO_ERR), 32'd0);
    CLR = 1'b0;
    wait_cyc(5);
    $display("txn reset done");

    cv_mark = cv_total;
    frame_begin();
    send_bits(8'hAA, 8);
    read_bits(9, rd_word);
    check_val("temp_cmd_valid_cnt", 32'(cv_total - cv_mark), 32'd1);
    check_val("temp_cmd", 32'(CMD), 32'hAA);
    check_val("temp_bits", rd_word, 32'h032);
    check_val("temp_oe_hold", 32'(DQ_OE), 32'd1);
    DS_RST = 1'b0;
    wait_cyc(HALF);
    check_val("temp_oe_release", 32'(DQ_OE), 32'd0);
    DS_CLK = 1'b0;
    wait_cyc(HALF);
    $display("txn READ_TEMP bits=0x%0h", rd_word);

    frame_begin();
    send_bits(CMD_WRITE_CFG, 8);
    send_bits(8'hA5, 8);
    frame_end();
    check_val("wcfg_cfg", 32'(CFG), 32'hA5);
    $display("txn WRITE_CFG 0xa5 cfg=0x%0h", CFG);

    frame_begin();
    send_bits(CMD_READ_CFG, 8);
    read_bits(8, rd_word);
    frame_end();
    check_val("rcfg_bits", rd_word, 32'hA5);
    check_val("rcfg_oe_release", 32'(DQ_OE), 32'd0);
    check_val("clean_proto_err", 32'(PROTO_ERR), 32'd0);
    $display("txn READ_CFG bits=0x%0h", rd_word);

    frame_begin();
    send_bits(CMD_START_CONV, 8);
    frame_end();
    check_val("start_conv", 32'(CONV_ACTIVE), 32'd1);
    frame_begin();
    send_bits(CMD_STOP_CONV, 8);
    frame_end();
    check_val("stop_conv", 32'(CONV_ACTIVE), 32'd0);
    $display("txn START/STOP_CONVERT conv=%0d", CONV_ACTIVE);

    frame_begin();
    send_bits(CMD_WRITE_CFG, 8);
    send_bits(8'h3C, 3);
    DS_RST = 1'b0;
    wait_cyc(HALF);
    check_val("abort_cfg", 32'(CFG), 32'hA5);
    check_val("abort_state", 32'(dut.state_reg), 32'(ST_IDLE));
    check_val("abort_oe", 32'(DQ_OE), 32'd0);
    check_val("abort_proto_err", 32'(PROTO_ERR), 32'(exp_perr));
    $display("txn partial WRITE_CFG cfg=0x%0h", CFG);

    CLR = 1'b1;
    wait_cyc(3);
    CLR = 1'b0;
    wait_cyc(3);
    cv_mark = cv_total;
    oe_seen = 1'b0;
    frame_begin();
    send_bits(8'h55, 8);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(HALF);
      oe_seen = oe_seen | DQ_OE;
      DS_CLK = 1'b1;
      wait_cyc(HALF);
      oe_seen = oe_seen | DQ_OE;
      DS_CLK = 1'b0;
    end
    frame_end();
    check_val("unk_oe", 32'(oe_seen), 32'd0);
    check_val("unk_cmd", 32'(CMD), 32'h55);
    check_val("unk_cmd_valid_cnt", 32'(cv_total - cv_mark), 32'd1);
    check_val("unk_proto_err", 32'(PROTO_ERR), 32'(exp_perr));
    check_val("unk_cfg", 32'(CFG), 32'h02);
    $display("txn unknown cmd=0x%0h perr=%0d", CMD, PROTO_ERR);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
